ext_unit_pipe: RTL and testbench

//  Parametrised, pipelined immediate/data extension unit for the MIPS datapath.

---
 rtl/ext_unit_pipe.sv | 139 +++++++++++++
 tb/tb_ext_unit_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ext_unit_pipe.sv
// Pipelined immediate/data extension unit with a valid/ready handshake and 2-entry skid buffer.
// Optional transfer counter port xfer_count is present when EXT_COUNT_EN is defined.
module ext_unit_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
`ifdef EXT_COUNT_EN
  ,
  output logic [31:0]      xfer_count
`endif
);

  localparam int unsigned Shift = OUT_W - IN_W;

  typedef enum logic [2:0] {
    ModeSign  = 3'd0,
    ModeZero  = 3'd1,
    ModeUpper = 3'd2,
    ModeSbyte = 3'd3,
    ModeZbyte = 3'd4
  } mode_e;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic             out_err_q, out_err_d;
  logic             skid_err_q, skid_err_d;
  logic             in_ready_q;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic             accept;
  logic             deliver;

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_mode)
      ModeSign:  ext_data = OUT_W'($signed(in_data));
      ModeZero:  ext_data = OUT_W'(in_data);
      ModeUpper: ext_data = OUT_W'(in_data) << Shift;
      ModeSbyte: ext_data = OUT_W'($signed(in_data[7:0]));
      ModeZbyte: ext_data = OUT_W'(in_data[7:0]);
      default:   ext_err  = 1'b1;
    endcase
  end

  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready_q;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d    = StOne;
          out_data_d = ext_data;
          out_err_d  = ext_err;
        end
      end
      StOne: begin
        if (accept && deliver) begin
          out_data_d = ext_data;
          out_err_d  = ext_err;
        end else if (accept) begin
          state_d     = StTwo;
          skid_data_d = ext_data;
          skid_err_d  = ext_err;
        end else if (deliver) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // in_ready is low here, so only the drain path exists.
        if (deliver) begin
          state_d    = StOne;
          out_data_d = skid_data_q;
          out_err_d  = skid_err_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= StEmpty;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      in_ready_q  <= (state_d != StTwo);
    end
  end

  assign in_ready = in_ready_q;
  assign out_data = out_data_q;
  assign out_err  = out_err_q;

`ifdef EXT_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (deliver) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign xfer_count = cnt_q;
`else
  // No transfer counter in this build.
`endif

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Scoreboard bench for ext_unit_pipe: stimulus pushes expected items, a negedge monitor pops them.
// Build with EXT_COUNT_EN defined to also exercise the transfer counter.
module tb_ext_unit_pipe;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
`ifdef EXT_COUNT_EN
  logic [31:0] xfer_count;
`endif

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];

  ext_unit_pipe #(
    .IN_W  (16),
    .OUT_W (32)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef EXT_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [2:0] m,
                      input logic [31:0] x, input logic e);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end else begin
      exp_q.push_back({e, x});
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    check("drain pending items", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: delivery happens on the next rising edge iff valid&ready&Reset_n at this negedge.
  logic        stall_seen = 1'b0;
  logic [31:0] held_data;
  logic        held_err;
  logic [32:0] exp_item;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && out_valid) begin
        check("stall hold data", out_data, held_data);
        check("stall hold err", out_err, held_err);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected output: got data %h err %b, expected no item", out_data,
                   out_err);
        end else begin
          exp_item = exp_q.pop_front();
          check("out_data", out_data, exp_item[31:0]);
          check("out_err", out_err, exp_item[32]);
        end
      end
      stall_seen = out_valid && !out_ready;
      held_data  = out_data;
      held_err   = out_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    repeat (2) step();
    check("reset out_valid", out_valid, 1'b0);
    check("reset in_ready", in_ready, 1'b0);
    check("reset out_data", out_data, 32'h0);
    check("reset out_err", out_err, 1'b0);
    Reset_n = 1'b1;
    step();
    check("in_ready after reset", in_ready, 1'b1);

    // 1: sign extend, one-cycle latency
    send(16'h8000, 3'd0, 32'hFFFF_8000, 1'b0);
    check("latency out_valid", out_valid, 1'b1);
    check("latency out_data", out_data, 32'hFFFF_8000);

    // 2: each mode, streamed back-to-back
    send(16'h8000, 3'd1, 32'h0000_8000, 1'b0);
    send(16'h1234, 3'd2, 32'h1234_0000, 1'b0);
    send(16'h0080, 3'd3, 32'hFFFF_FF80, 1'b0);
    send(16'hAB80, 3'd4, 32'h0000_0080, 1'b0);
    send(16'h7FFF, 3'd0, 32'h0000_7FFF, 1'b0);
    send(16'hFFFF, 3'd2, 32'hFFFF_0000, 1'b0);
    send(16'h127F, 3'd3, 32'h0000_007F, 1'b0);
    drain();

    // 3: fill both entries under backpressure, then drain in order
    out_ready = 1'b0;
    send(16'h0001, 3'd0, 32'h0000_0001, 1'b0);
    send(16'h0002, 3'd0, 32'h0000_0002, 1'b0);
    check("full in_ready", in_ready, 1'b0);
    check("full out_data head", out_data, 32'h0000_0001);
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    repeat (2) step();
    in_valid = 1'b0;
    check("full still blocked", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    check("after A out_data", out_data, 32'h0000_0002);
    check("after A in_ready", in_ready, 1'b1);
    step();
    check("after B out_valid", out_valid, 1'b0);
    drain();

    // 4: reserved modes flag an error, next item clean
    send(16'hFFFF, 3'd6, 32'h0, 1'b1);
    send(16'h0005, 3'd0, 32'h0000_0005, 1'b0);
    send(16'h1234, 3'd5, 32'h0, 1'b1);
    send(16'h4321, 3'd7, 32'h0, 1'b1);
    send(16'h00FF, 3'd1, 32'h0000_00FF, 1'b0);
    drain();

    // 5: reset while both entries hold items
    out_ready = 1'b0;
    send(16'h0011, 3'd0, 32'h0000_0011, 1'b0);
    send(16'h0022, 3'd0, 32'h0000_0022, 1'b0);
    Reset_n = 1'b0;
    exp_q.delete();
    step();
    check("mid reset out_valid", out_valid, 1'b0);
    check("mid reset in_ready", in_ready, 1'b0);
    check("mid reset out_data", out_data, 32'h0);
    Reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    check("post reset in_ready", in_ready, 1'b1);
    repeat (3) step();
    check("no stale item", out_valid, 1'b0);
    send(16'hFF80, 3'd3, 32'hFFFF_FF80, 1'b0);
    drain();

`ifdef EXT_COUNT_EN
    // 6: delivery counter and wrap
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    step();
    check("count reset", xfer_count, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(16'(i), 3'd1, 32'(i), 1'b0);
    end
    drain();
    check("count five", xfer_count, 32'd5);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    send(16'h0009, 3'd6, 32'h0, 1'b1);
    drain();
    check("count wrap", xfer_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
